// File: rtl/pr_video_stream_decoupler.sv
// Frame-aligned AXI4-Stream decoupler between a reconfigurable video filter and the video output.
// Define PR_DECOUP_LINECHK_EN to add the per-line width checker and its err_line_cnt port.
module pr_video_stream_decoupler #(
  parameter int DATA_W     = 24,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              decouple_req,
  input  logic [11:0]       cfg_lines,
  input  logic [11:0]       cfg_width,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              decoupled,
  output logic              rp_reset,
  output logic              timeout_flag,
  output logic [15:0]       frame_cnt
`ifdef PR_DECOUP_LINECHK_EN
  ,
  output logic [7:0]        err_line_cnt
`endif
);

  localparam logic [2:0] ST_DECOUPLED = 3'd0;
  localparam logic [2:0] ST_RST_HOLD  = 3'd1;
  localparam logic [2:0] ST_SYNC      = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  localparam int RST_W  = $clog2(RST_CYCLES) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;
  localparam int BEAT_W = DATA_W + 2;

  logic [2:0]        state_reg, state_next;
  logic [RST_W-1:0]  rst_cnt_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic [11:0]       line_cnt_reg;
  logic              pending_reg;
  logic              timeout_reg;
  logic [15:0]       frame_cnt_reg;
  logic              out_valid_reg, sk_valid_reg;
  logic [BEAT_W-1:0] out_beat_reg, sk_beat_reg;

  logic              accept, pop, eof, timeout_hit;
  logic [11:0]       line_base;
  logic [BEAT_W-1:0] in_beat;

  assign in_beat = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  assign accept  = (state_reg == ST_RUN) && s_axis_tvalid && !sk_valid_reg;
  assign pop     = out_valid_reg && m_axis_tready;

  // A SOF beat restarts the line count before the end-of-frame test looks at it.
  assign line_base   = s_axis_tuser ? 12'd0 : line_cnt_reg;
  assign eof         = accept && s_axis_tlast && (line_base == cfg_lines - 12'd1);
  assign timeout_hit = (state_reg == ST_RUN) && pending_reg && !accept &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_reg)
      ST_DECOUPLED, ST_RST_HOLD: s_axis_tready = 1'b1;
      ST_SYNC:                   s_axis_tready = ~s_axis_tuser;
      ST_RUN:                    s_axis_tready = ~sk_valid_reg;
      default:                   s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_DECOUPLED: if (!decouple_req) state_next = ST_RST_HOLD;
      ST_RST_HOLD: begin
        if (decouple_req)                                  state_next = ST_DECOUPLED;
        else if (rst_cnt_reg == RST_W'(RST_CYCLES - 1))    state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (decouple_req)                      state_next = ST_DRAIN;
        else if (s_axis_tvalid && s_axis_tuser) state_next = ST_RUN;
      end
      ST_RUN: if ((eof && (pending_reg || decouple_req)) || timeout_hit) state_next = ST_DRAIN;
      ST_DRAIN: if (!out_valid_reg && !sk_valid_reg) state_next = ST_DECOUPLED;
      default: state_next = ST_DECOUPLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_DECOUPLED;
      rst_cnt_reg   <= '0;
      idle_cnt_reg  <= '0;
      line_cnt_reg  <= '0;
      pending_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      out_beat_reg  <= '0;
      sk_valid_reg  <= 1'b0;
      sk_beat_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= (state_reg == ST_RST_HOLD) ? rst_cnt_reg + RST_W'(1) : '0;

      if (state_reg == ST_RUN && state_next == ST_RUN) pending_reg <= pending_reg | decouple_req;
      else                                             pending_reg <= 1'b0;

      if (state_reg == ST_RUN && state_next == ST_RUN && pending_reg && !accept)
        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      else
        idle_cnt_reg <= '0;

      if (timeout_hit) timeout_reg <= 1'b1;

      if (accept) begin
        if (s_axis_tlast) line_cnt_reg <= eof ? 12'd0 : line_base + 12'd1;
        else              line_cnt_reg <= line_base;
        if (s_axis_tuser) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end

      // Two-entry skid: out stage feeds the master port, the skid entry absorbs one stalled beat.
      if (!out_valid_reg || pop) begin
        if (sk_valid_reg) begin
          out_beat_reg  <= sk_beat_reg;
          out_valid_reg <= 1'b1;
          sk_valid_reg  <= 1'b0;
        end else begin
          out_valid_reg <= accept;
          if (accept) out_beat_reg <= in_beat;
        end
      end else if (accept) begin
        sk_beat_reg  <= in_beat;
        sk_valid_reg <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = out_beat_reg;
  assign decoupled     = (state_reg == ST_DECOUPLED) || (state_reg == ST_RST_HOLD);
  assign rp_reset      = decoupled;
  assign timeout_flag  = timeout_reg;
  assign frame_cnt     = frame_cnt_reg;

`ifdef PR_DECOUP_LINECHK_EN
  logic [11:0] pix_cnt_reg;
  logic [7:0]  err_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else if (state_reg != ST_RUN) begin
      pix_cnt_reg <= '0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        pix_cnt_reg <= '0;
        if ((({1'b0, pix_cnt_reg} + 13'd1) != {1'b0, cfg_width}) && (err_cnt_reg != 8'hFF))
          err_cnt_reg <= err_cnt_reg + 8'd1;
      end else begin
        pix_cnt_reg <= pix_cnt_reg + 12'd1;
      end
    end
  end

  assign err_line_cnt = err_cnt_reg;
`else
  logic unused_cfg_width;
  assign unused_cfg_width = ^cfg_width;
`endif

endmodule

// File: tb/tb_pr_video_stream_decoupler.sv
// Randomized self-checking bench for pr_video_stream_decoupler; expected output is the ordered
// list of beats sent after resynchronisation, scored by an in-order monitor on the master side.
module tb_pr_video_stream_decoupler;
  localparam int DATA_W     = 24;
  localparam int RST_CYCLES = 16;
  localparam int TIMEOUT    = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, decouple_req;
  logic [11:0]       cfg_lines, cfg_width;
  logic [DATA_W-1:0] s_axis_tdata, m_axis_tdata;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic              decoupled, rp_reset, timeout_flag;
  logic [15:0]       frame_cnt;
`ifdef PR_DECOUP_LINECHK_EN
  logic [7:0]        err_line_cnt;
`endif

  pr_video_stream_decoupler #(.DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .decouple_req(decouple_req),
    .cfg_lines(cfg_lines), .cfg_width(cfg_width),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .decoupled(decoupled), .rp_reset(rp_reset), .timeout_flag(timeout_flag), .frame_cnt(frame_cnt)
`ifdef PR_DECOUP_LINECHK_EN
    , .err_line_cnt(err_line_cnt)
`endif
  );

  typedef struct packed {
    logic              user;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_frames  = 0;
  beat_t exp_q[$];
  bit    rand_ready     = 1'b0;
  bit    hold_ready_low = 1'b0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Master-side ready pattern, changed just after each active edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      cycle();
      if (hold_ready_low)  m_axis_tready = 1'b0;
      else if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      else                 m_axis_tready = 1'b1;
    end
  end

  // In-order scoreboard plus hold-stable check on the master port.
  initial begin
    beat_t got, want, held;
    bit    stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          vectors++;
          if (!m_axis_tvalid || got !== held) begin
            miscompares++;
            $display("FAIL m_stable: got valid=%0b beat=%h, want valid=1 beat=%h", m_axis_tvalid, got, held);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL m_beat: got unexpected beat %h, want none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              miscompares++;
              $display("FAIL m_beat: got %h, want %h", got, want);
            end
          end
          stalled = 1'b0;
        end else if (m_axis_tvalid) begin
          stalled = 1'b1;
          held    = got;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic u, input logic l, input bit fwd);
    int    waited = 0;
    bit    done   = 1'b0;
    beat_t b;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) begin
        done = 1'b1;
        if (fwd) begin
          b = {u, l, d};
          exp_q.push_back(b);
        end
      end else if (++waited > 200) begin
        vectors++; miscompares++;
        $display("FAIL s_accept: tready low for %0d cycles, want beat accepted", waited);
        done = 1'b1;
      end
    end
    cycle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int width, input int pulse_at);
    int idx = 0;
    for (int ln = 0; ln < lines; ln++) begin
      for (int px = 0; px < width; px++) begin
        repeat ($urandom_range(0, 2)) cycle();
        if (idx == pulse_at) decouple_req = 1'b1;
        send_beat(DATA_W'($urandom), (ln == 0 && px == 0), (px == width - 1), 1'b1);
        if (idx == pulse_at) decouple_req = 1'b0;
        idx++;
      end
    end
    exp_frames++;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin cycle(); n++; end
    vectors++;
    if (exp_q.size() != 0 || m_axis_tvalid) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats pending valid=%0b, want 0 pending valid=0", tag, exp_q.size(), m_axis_tvalid);
    end
  endtask

  task automatic wait_decoupled(input logic want, input string tag);
    int n = 0;
    while (decoupled !== want && n < 300) begin cycle(); n++; end
    vectors++;
    if (decoupled !== want) begin
      miscompares++;
      $display("FAIL %s_decoupled: got %0b after %0d cycles, want %0b", tag, decoupled, n, want);
    end
  endtask

  task automatic check_frame_cnt(input string tag);
    vectors++;
    if (frame_cnt !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL %s_frame_cnt: got %0d, want %0d", tag, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; decouple_req = 1'b1; cfg_lines = 12'd2; cfg_width = 12'd4;
    s_axis_tvalid = 1'b1; s_axis_tdata = DATA_W'($urandom); s_axis_tuser = 1'b1; s_axis_tlast = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    @(negedge clk);
    vectors += 9;
    if (decoupled !== 1'b1)     begin miscompares++; $display("FAIL rst_decoupled: got %0b, want 1", decoupled); end
    if (rp_reset !== 1'b1)      begin miscompares++; $display("FAIL rst_rp_reset: got %0b, want 1", rp_reset); end
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL rst_s_tready: got %0b, want 1", s_axis_tready); end
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %0b, want 0", m_axis_tvalid); end
    if (m_axis_tdata !== '0)    begin miscompares++; $display("FAIL rst_m_tdata: got %h, want 0", m_axis_tdata); end
    if (m_axis_tuser !== 1'b0)  begin miscompares++; $display("FAIL rst_m_tuser: got %0b, want 0", m_axis_tuser); end
    if (m_axis_tlast !== 1'b0)  begin miscompares++; $display("FAIL rst_m_tlast: got %0b, want 0", m_axis_tlast); end
    if (timeout_flag !== 1'b0)  begin miscompares++; $display("FAIL rst_timeout: got %0b, want 0", timeout_flag); end
    if (frame_cnt !== 16'd0)    begin miscompares++; $display("FAIL rst_frame_cnt: got %0d, want 0", frame_cnt); end
`ifdef PR_DECOUP_LINECHK_EN
    vectors++;
    if (err_line_cnt !== 8'd0)  begin miscompares++; $display("FAIL rst_err_line: got %0d, want 0", err_line_cnt); end
`endif
    // RP beats are swallowed while decoupled.
    for (int i = 0; i < 10; i++) begin
      cycle();
      s_axis_tvalid = 1'($urandom_range(0, 1)); s_axis_tdata = DATA_W'($urandom);
      s_axis_tuser = 1'($urandom_range(0, 1)); s_axis_tlast = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL swallow: got tready=%0b m_tvalid=%0b, want 1/0", s_axis_tready, m_axis_tvalid);
      end
    end
    cycle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_rst_hold();
    int high = 0;
    bit done = 1'b0;
    reset = 1'b1; decouple_req = 1'b0;
    cycle();
    reset = 1'b0;
    exp_frames = 0;
    // One cycle in DECOUPLED, then RST_CYCLES cycles in RST_HOLD.
    while (!done && high < 100) begin
      @(negedge clk);
      vectors++;
      if (decoupled !== rp_reset) begin
        miscompares++;
        $display("FAIL hold_track: got decoupled=%0b rp_reset=%0b, want equal", decoupled, rp_reset);
      end
      if (rp_reset === 1'b1) high++; else done = 1'b1;
    end
    vectors++;
    if (high != RST_CYCLES + 1) begin
      miscompares++;
      $display("FAIL hold_len: got rp_reset high %0d cycles, want %0d", high, RST_CYCLES + 1);
    end
    cycle();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL sync_tready_sof: got %0b, want 0", s_axis_tready); end
    cycle();
    s_axis_tuser = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL sync_tready_data: got %0b, want 1", s_axis_tready); end
    cycle();
  endtask

  task automatic test_sync();
    rand_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(DATA_W'($urandom), 1'b0, (i == 2), 1'b0);
    send_frame(2, 4, -1);
    wait_drain("sync");
    check_frame_cnt("sync");
  endtask

  task automatic test_frames();
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(2, 4, -1);
    wait_drain("frames");
    check_frame_cnt("frames");
  endtask

  task automatic test_decouple_eof();
    // A lone line then a fresh SOF: the restarted line count decides where the frame ends.
    send_frame(1, 4, -1);
    send_frame(2, 4, 2);
    wait_drain("decouple");
    wait_decoupled(1'b1, "decouple");
    vectors += 2;
    if (rp_reset !== 1'b1)      begin miscompares++; $display("FAIL decouple_rp_reset: got %0b, want 1", rp_reset); end
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL decouple_m_tvalid: got %0b, want 0", m_axis_tvalid); end
    check_frame_cnt("decouple");
    wait_decoupled(1'b0, "recouple1");
  endtask

  task automatic test_boundary();
    cfg_lines = 12'd1; cfg_width = 12'd1;
    for (int i = 0; i < 4; i++) send_beat(DATA_W'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    send_frame(1, 1, -1);
    send_frame(1, 1, -1);
    send_frame(1, 1, 0);
    wait_drain("boundary");
    wait_decoupled(1'b1, "boundary");
    check_frame_cnt("boundary");
    cfg_lines = 12'd2; cfg_width = 12'd4;
    wait_decoupled(1'b0, "recouple2");
  endtask

  task automatic test_timeout();
    int low = 0;
    send_beat(DATA_W'($urandom), 1'b1, 1'b0, 1'b1);
    send_beat(DATA_W'($urandom), 1'b0, 1'b0, 1'b1);
    exp_frames++;
    decouple_req = 1'b1;
    while (timeout_flag !== 1'b1 && low < TIMEOUT + 100) begin @(negedge clk); if (timeout_flag !== 1'b1) low++; end
    vectors++;
    if (low < TIMEOUT || low > TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL timeout_len: got flag after %0d cycles, want %0d..%0d", low, TIMEOUT, TIMEOUT + 2);
    end
    cycle();
    wait_drain("timeout");
    wait_decoupled(1'b1, "timeout");
    decouple_req = 1'b0;
    wait_decoupled(1'b0, "recouple3");
    repeat (20) cycle();
    vectors++;
    if (timeout_flag !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %0b, want 1", timeout_flag); end
    check_frame_cnt("timeout");
  endtask

  task automatic test_reset_midframe();
    rand_ready = 1'b0; hold_ready_low = 1'b1;
    cycle(); cycle();
    send_beat(DATA_W'($urandom), 1'b1, 1'b0, 1'b1);
    send_beat(DATA_W'($urandom), 1'b0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL skid_full: got tready=%0b, want 0", s_axis_tready); end
    cycle();
    reset = 1'b1;
    exp_q.delete();
    cycle();
    reset = 1'b0; decouple_req = 1'b1; s_axis_tvalid = 1'b0; hold_ready_low = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    vectors += 4;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_m_tvalid: got %0b, want 0", m_axis_tvalid); end
    if (decoupled !== 1'b1)     begin miscompares++; $display("FAIL midrst_decoupled: got %0b, want 1", decoupled); end
    if (timeout_flag !== 1'b0)  begin miscompares++; $display("FAIL midrst_timeout: got %0b, want 0", timeout_flag); end
    if (m_axis_tdata !== '0)    begin miscompares++; $display("FAIL midrst_m_tdata: got %h, want 0", m_axis_tdata); end
    check_frame_cnt("midrst");
    cycle();
  endtask

`ifdef PR_DECOUP_LINECHK_EN
  task automatic test_linechk();
    decouple_req = 1'b0; cfg_lines = 12'd4095; cfg_width = 12'd4;
    wait_decoupled(1'b0, "linechk");
    for (int px = 0; px < 4; px++) send_beat(DATA_W'($urandom), (px == 0), (px == 3), 1'b1);
    wait_drain("linechk_good");
    vectors++;
    if (err_line_cnt !== 8'd0) begin miscompares++; $display("FAIL linechk_good: got %0d, want 0", err_line_cnt); end
    for (int px = 0; px < 3; px++) send_beat(DATA_W'($urandom), 1'b0, (px == 2), 1'b1);
    wait_drain("linechk_short");
    vectors++;
    if (err_line_cnt !== 8'd1) begin miscompares++; $display("FAIL linechk_short: got %0d, want 1", err_line_cnt); end
    for (int i = 0; i < 300; i++) send_beat(DATA_W'($urandom), 1'b0, 1'b1, 1'b1);
    wait_drain("linechk_sat");
    vectors++;
    if (err_line_cnt !== 8'd255) begin miscompares++; $display("FAIL linechk_sat: got %0d, want 255", err_line_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; decouple_req = 1'b1; cfg_lines = 12'd2; cfg_width = 12'd4;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    test_reset();
    test_rst_hold();
    test_sync();
    test_frames();
    test_decouple_eof();
    test_boundary();
    test_timeout();
    test_reset_midframe();
`ifdef PR_DECOUP_LINECHK_EN
    test_linechk();
`endif
    repeat (5) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
